// File: rtl/main_dec_pipe.sv
// MIPS-I main decoder with E/M/W control pipeline, stall/flush per stage,
// reserved-instruction detection and a multi-cycle HI/LO busy tracker.
module main_dec_pipe #(
  parameter int MUL_LATENCY = 1,
  parameter int DIV_LATENCY = 32,
  parameter bit HILO_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrD,
  input  logic        stallE,
  input  logic        flushE,
  input  logic        stallM,
  input  logic        flushM,
  input  logic        stallW,
  input  logic        flushW,
  output logic        branchD,
  output logic        jumpD,
  output logic        jrD,
  output logic        riD,
  output logic        regwriteE,
  output logic        regdstE,
  output logic        alusrcAE,
  output logic        alusrcBE,
  output logic        memtoRegE,
  output logic        jalE,
  output logic        balE,
  output logic        regwriteM,
  output logic        memWriteM,
  output logic        memtoRegM,
  output logic        hilowriteM,
  output logic        riM,
  output logic        regwriteW,
  output logic        memtoRegW,
  output logic        md_stall
);

  typedef struct packed {
    logic ri, md, hilowrite, bal, jr, jal, alusrcA;
    logic regwrite, regdst, alusrcB, branch, memWrite, memtoReg, jump;
  } ctrl_t;

  typedef enum logic {IDLE, BUSY} md_st_t;

  localparam int MAXL = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] MUL_L = CW'(MUL_LATENCY);
  localparam logic [CW-1:0] DIV_L = CW'(DIV_LATENCY);
  localparam bit MUL_MULTI = (MUL_LATENCY > 1);
  localparam bit DIV_MULTI = (DIV_LATENCY > 1);

  logic [5:0] op, funct;
  logic [4:0] rt;
  ctrl_t      d, e, m, w;
  logic       divd, dive;

  assign op    = instrD[31:26];
  assign rt    = instrD[20:16];
  assign funct = instrD[5:0];

  // an RI word only ever sets ri, so each illegal branch assigns nothing else
  always_comb begin
    d    = '0;
    divd = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b000000, 6'b000010, 6'b000011: begin
            d.alusrcA = 1'b1; d.regwrite = 1'b1; d.regdst = 1'b1;
          end
          6'b000100, 6'b000110, 6'b000111,
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011: begin
            d.regwrite = 1'b1; d.regdst = 1'b1;
          end
          6'b010000, 6'b010010:
            if (HILO_EN) begin d.regwrite = 1'b1; d.regdst = 1'b1; end
            else d.ri = 1'b1;
          6'b010001, 6'b010011:
            if (HILO_EN) d.hilowrite = 1'b1;
            else d.ri = 1'b1;
          6'b011000, 6'b011001, 6'b011010, 6'b011011:
            if (HILO_EN) begin
              d.hilowrite = 1'b1; d.md = 1'b1; divd = funct[1];
            end else d.ri = 1'b1;
          6'b001000: begin d.jr = 1'b1; d.jump = 1'b1; end
          6'b001001: begin
            d.jr = 1'b1; d.jump = 1'b1; d.regwrite = 1'b1; d.regdst = 1'b1;
          end
          default: d.ri = 1'b1;
        endcase
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        d.regwrite = 1'b1; d.alusrcB = 1'b1; d.memtoReg = 1'b1;
      end
      6'b101000, 6'b101001, 6'b101011: begin
        d.alusrcB = 1'b1; d.memWrite = 1'b1;
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        d.regwrite = 1'b1; d.alusrcB = 1'b1;
      end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: d.branch = 1'b1;
      6'b000001: begin
        case (rt)
          5'b00000, 5'b00001: d.branch = 1'b1;
          5'b10000, 5'b10001: begin
            d.branch = 1'b1; d.bal = 1'b1; d.regwrite = 1'b1;
          end
          default: d.ri = 1'b1;
        endcase
      end
      6'b000010: d.jump = 1'b1;
      6'b000011: begin d.jump = 1'b1; d.jal = 1'b1; d.regwrite = 1'b1; end
      default: d.ri = 1'b1;
    endcase
  end

  assign branchD = d.branch;
  assign jumpD   = d.jump;
  assign jrD     = d.jr;
  assign riD     = d.ri;

  // MD busy tracker
  md_st_t        st, st_nx;
  logic [CW-1:0] cnt, cnt_nx, lat, lat_nx, lat_m1, le;
  logic          lmulti;

  assign le     = dive ? DIV_L : MUL_L;
  assign lmulti = dive ? DIV_MULTI : MUL_MULTI;
  assign lat_m1 = lat - ONE;

  always_comb begin
    st_nx    = st;
    cnt_nx   = cnt;
    lat_nx   = lat;
    md_stall = 1'b0;
    case (st)
      IDLE:
        if (e.md && lmulti) begin
          md_stall = !flushE;
          st_nx    = BUSY;
          cnt_nx   = ONE;
          lat_nx   = le;
        end
      BUSY:
        if (cnt != lat_m1) begin
          md_stall = 1'b1;
          cnt_nx   = cnt + ONE;
        end else if (!stallE) begin
          st_nx  = IDLE;
          cnt_nx = '0;
        end
      default: st_nx = IDLE;
    endcase
    if (flushE) begin
      st_nx  = IDLE;
      cnt_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      cnt <= '0;
      lat <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      lat <= lat_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      e    <= '0;
      dive <= 1'b0;
    end else if (!(stallE || md_stall)) begin
      e    <= d;
      dive <= divd;
    end
  end

  // M takes a bubble while E is frozen by the MD tracker
  always_ff @(posedge clk) begin
    if (rst || flushM)  m <= '0;
    else if (stallM)    m <= m;
    else if (md_stall)  m <= '0;
    else                m <= e;
  end

  always_ff @(posedge clk) begin
    if (rst || flushW)  w <= '0;
    else if (!stallW)   w <= m;
  end

  assign regwriteE  = e.regwrite;
  assign regdstE    = e.regdst;
  assign alusrcAE   = e.alusrcA;
  assign alusrcBE   = e.alusrcB;
  assign memtoRegE  = e.memtoReg;
  assign jalE       = e.jal;
  assign balE       = e.bal;
  assign regwriteM  = m.regwrite;
  assign memWriteM  = m.memWrite;
  assign memtoRegM  = m.memtoReg;
  assign hilowriteM = m.hilowrite;
  assign riM        = m.ri;
  assign regwriteW  = w.regwrite;
  assign memtoRegW  = w.memtoReg;

  logic unused_bits;
  assign unused_bits = ^{instrD[25:21], instrD[15:6],
                         m.md, m.bal, m.jr, m.jal, m.alusrcA, m.regdst,
                         m.alusrcB, m.branch, m.jump,
                         w.ri, w.md, w.hilowrite, w.bal, w.jr, w.jal,
                         w.alusrcA, w.regdst, w.alusrcB, w.branch,
                         w.memWrite, w.jump};

endmodule

// File: tb/tb_main_dec_pipe.sv
// Bench for main_dec_pipe: directed scenarios plus randomized traffic
// checked against a time-in-stage reference model.
module tb_main_dec_pipe;

  localparam int MUL = 1;
  localparam int DIV = 32;

  localparam logic [13:0] B_RI = 14'h2000, B_MD = 14'h1000, B_HW = 14'h0800,
                          B_BAL = 14'h0400, B_JR = 14'h0200, B_JAL = 14'h0100,
                          B_AA = 14'h0080, B_RW = 14'h0040, B_RD = 14'h0020,
                          B_AB = 14'h0010, B_BR = 14'h0008, B_MW = 14'h0004,
                          B_MR = 14'h0002, B_J = 14'h0001;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] instrD;
  logic stallE, flushE, stallM, flushM, stallW, flushW;
  logic branchD, jumpD, jrD, riD;
  logic regwriteE, regdstE, alusrcAE, alusrcBE, memtoRegE, jalE, balE;
  logic regwriteM, memWriteM, memtoRegM, hilowriteM, riM;
  logic regwriteW, memtoRegW, md_stall;
  logic h0_riD;
  logic [17:0] h0_unused_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  main_dec_pipe #(.MUL_LATENCY(MUL), .DIV_LATENCY(DIV), .HILO_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .instrD(instrD),
    .stallE(stallE), .flushE(flushE), .stallM(stallM), .flushM(flushM),
    .stallW(stallW), .flushW(flushW),
    .branchD(branchD), .jumpD(jumpD), .jrD(jrD), .riD(riD),
    .regwriteE(regwriteE), .regdstE(regdstE), .alusrcAE(alusrcAE),
    .alusrcBE(alusrcBE), .memtoRegE(memtoRegE), .jalE(jalE), .balE(balE),
    .regwriteM(regwriteM), .memWriteM(memWriteM), .memtoRegM(memtoRegM),
    .hilowriteM(hilowriteM), .riM(riM),
    .regwriteW(regwriteW), .memtoRegW(memtoRegW), .md_stall(md_stall)
  );

  main_dec_pipe #(.MUL_LATENCY(3), .DIV_LATENCY(2), .HILO_EN(1'b0)) u_h0 (
    .clk(clk), .rst(rst), .instrD(instrD),
    .stallE(stallE), .flushE(flushE), .stallM(stallM), .flushM(flushM),
    .stallW(stallW), .flushW(flushW),
    .branchD(h0_unused_o[0]), .jumpD(h0_unused_o[1]), .jrD(h0_unused_o[2]),
    .riD(h0_riD),
    .regwriteE(h0_unused_o[3]), .regdstE(h0_unused_o[4]),
    .alusrcAE(h0_unused_o[5]), .alusrcBE(h0_unused_o[6]),
    .memtoRegE(h0_unused_o[7]), .jalE(h0_unused_o[8]), .balE(h0_unused_o[9]),
    .regwriteM(h0_unused_o[10]), .memWriteM(h0_unused_o[11]),
    .memtoRegM(h0_unused_o[12]), .hilowriteM(h0_unused_o[13]),
    .riM(h0_unused_o[14]), .regwriteW(h0_unused_o[15]),
    .memtoRegW(h0_unused_o[16]), .md_stall(h0_unused_o[17])
  );

  function automatic logic [13:0] ref_dec(input logic [31:0] i, input bit hilo);
    logic [5:0] op, fn;
    logic [4:0] rt;
    logic [13:0] c;
    op = i[31:26]; rt = i[20:16]; fn = i[5:0]; c = '0;
    if (op == 6'd0) begin
      if (fn inside {6'd0, 6'd2, 6'd3})                         c = B_AA | B_RW | B_RD;
      else if (fn inside {6'd4, 6'd6, 6'd7, [6'd32:6'd39], 6'd42, 6'd43}) c = B_RW | B_RD;
      else if (fn inside {6'd16, 6'd18})                        c = B_RW | B_RD;
      else if (fn inside {6'd17, 6'd19})                        c = B_HW;
      else if (fn inside {[6'd24:6'd27]})                       c = B_HW | B_MD;
      else if (fn == 6'd8)                                      c = B_JR | B_J;
      else if (fn == 6'd9)                                      c = B_JR | B_J | B_RW | B_RD;
      else                                                      c = B_RI;
      if (!hilo && (fn inside {[6'd16:6'd19], [6'd24:6'd27]}))  c = B_RI;
    end
    else if (op inside {6'd32, 6'd33, 6'd35, 6'd36, 6'd37}) c = B_RW | B_AB | B_MR;
    else if (op inside {6'd40, 6'd41, 6'd43})               c = B_AB | B_MW;
    else if (op inside {[6'd8:6'd15]})                      c = B_RW | B_AB;
    else if (op inside {[6'd4:6'd7]})                       c = B_BR;
    else if (op == 6'd1) begin
      if (rt inside {5'd0, 5'd1})        c = B_BR;
      else if (rt inside {5'd16, 5'd17}) c = B_BR | B_BAL | B_RW;
      else                               c = B_RI;
    end
    else if (op == 6'd2) c = B_J;
    else if (op == 6'd3) c = B_J | B_JAL | B_RW;
    else                 c = B_RI;
    return c;
  endfunction

  function automatic bit is_div(input logic [31:0] i);
    return (i[31:26] == 6'd0) && (i[5:0] inside {6'd26, 6'd27});
  endfunction

  // Reference: an MD op is held in E until it has been there L-1 cycles.
  logic [13:0] me, mm, mw;
  bit          mdiv;
  int          age;
  bit          exp_mdst;

  always_comb begin
    int l;
    l = mdiv ? DIV : MUL;
    exp_mdst = me[12] && (l > 1) && (age < l - 1) && !(flushE && age == 0);
  end

  always @(posedge clk) begin
    if (rst) begin
      me <= '0; mm <= '0; mw <= '0; mdiv <= 1'b0; age <= 0;
    end else begin
      if (flushE) begin
        me <= '0; mdiv <= 1'b0; age <= 0;
      end else if (stallE || exp_mdst) begin
        age <= age + 1;
      end else begin
        me <= ref_dec(instrD, 1'b1); mdiv <= is_div(instrD); age <= 0;
      end
      if (flushM)        mm <= '0;
      else if (stallM)   mm <= mm;
      else if (exp_mdst) mm <= '0;
      else               mm <= me;
      if (flushW)        mw <= '0;
      else if (!stallW)  mw <= mm;
    end
  end

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] LW   = 32'h8c43_0010;
  localparam logic [31:0] DIVI = 32'h0064_001a;
  localparam logic [31:0] MULT = 32'h0064_0018;
  localparam logic [31:0] ADDU = 32'h0064_2821;
  localparam logic [31:0] MFHI = 32'h0000_2010;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic ctl_clear();
    stallE = 0; flushE = 0; stallM = 0; flushM = 0; stallW = 0; flushW = 0;
  endtask

  task automatic test_reset();
    logic [20:0] all;
    rst = 1'b1; instrD = LW; ctl_clear();
    tick(); tick();
    all = {branchD, jumpD, jrD, riD, regwriteE, regdstE, alusrcAE, alusrcBE,
           memtoRegE, jalE, balE, regwriteM, memWriteM, memtoRegM, hilowriteM,
           riM, regwriteW, memtoRegW, md_stall, 2'b00};
    total++;
    if (all !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all); end
    rst = 1'b0;
    tick();
    total++;
    if ({regwriteE, regdstE, alusrcAE, alusrcBE, memtoRegE, jalE, balE} !== 7'b1001100) begin
      bad++;
      $display("FAIL lw_E got=%b exp=1001100",
               {regwriteE, regdstE, alusrcAE, alusrcBE, memtoRegE, jalE, balE});
    end
    instrD = NOP;
    tick(); tick();
    total++;
    if ({regwriteW, memtoRegW} !== 2'b11) begin
      bad++; $display("FAIL lw_W got=%b exp=11", {regwriteW, memtoRegW});
    end
  endtask

  task automatic test_div();
    int n;
    instrD = DIVI;
    tick();
    instrD = ADDU;
    n = 0;
    while (md_stall === 1'b1 && n < 40) begin
      total++;
      if (hilowriteM !== 1'b0 || (n > 0 && regwriteM !== 1'b0)) begin
        bad++;
        $display("FAIL div_bubble cyc=%0d got hw=%b rw=%b exp=0", n, hilowriteM, regwriteM);
      end
      n++;
      tick();
    end
    total++;
    if (n != DIV - 1) begin bad++; $display("FAIL div_stall_len got=%0d exp=%0d", n, DIV - 1); end
    total++;
    if (hilowriteM !== 1'b0) begin bad++; $display("FAIL div_release_M got=%b exp=0", hilowriteM); end
    tick();
    total++;
    if ({hilowriteM, regwriteE, md_stall} !== 3'b110) begin
      bad++; $display("FAIL div_exit got=%b exp=110", {hilowriteM, regwriteE, md_stall});
    end
  endtask

  task automatic test_mult();
    instrD = MULT;
    tick();
    total++;
    if (md_stall !== 1'b0) begin bad++; $display("FAIL mult_stall got=%b exp=0", md_stall); end
    instrD = ADDU;
    tick();
    total++;
    if ({hilowriteM, regwriteM, md_stall} !== 3'b100) begin
      bad++; $display("FAIL mult_M got=%b exp=100", {hilowriteM, regwriteM, md_stall});
    end
    instrD = NOP;
    tick();
    total++;
    if ({hilowriteM, regwriteM} !== 2'b01) begin
      bad++; $display("FAIL addu_M got=%b exp=01", {hilowriteM, regwriteM});
    end
  endtask

  task automatic test_flush();
    instrD = DIVI;
    tick();
    instrD = ADDU;
    repeat (5) tick();
    flushE = 1'b1;
    #1;
    total++;
    if (md_stall !== 1'b1) begin bad++; $display("FAIL flush_busy_stall got=%b exp=1", md_stall); end
    tick();
    flushE = 1'b0;
    #1;
    total++;
    if ({md_stall, regwriteE, regdstE, alusrcAE, alusrcBE, memtoRegE, jalE, balE} !== 8'd0) begin
      bad++;
      $display("FAIL flush_E got=%b exp=0",
               {md_stall, regwriteE, regdstE, alusrcAE, alusrcBE, memtoRegE, jalE, balE});
    end
    tick();
    total++;
    if ({regwriteE, md_stall} !== 2'b10) begin
      bad++; $display("FAIL flush_resume got=%b exp=10", {regwriteE, md_stall});
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (hilowriteM !== 1'b0) begin bad++; $display("FAIL flush_no_hw cyc=%0d got=%b exp=0", k, hilowriteM); end
      tick();
    end
  endtask

  task automatic test_ri();
    logic [31:0] r;
    r = $urandom();
    instrD = {6'b111111, r[25:0]};
    #1;
    total++;
    if ({riD, branchD, jumpD, jrD} !== 4'b1000) begin
      bad++; $display("FAIL ri_op3f got=%b exp=1000", {riD, branchD, jumpD, jrD});
    end
    instrD = {6'b000001, r[25:21], 5'b00010, r[15:0]};
    #1;
    total++;
    if ({riD, branchD, jumpD, jrD} !== 4'b1000) begin
      bad++; $display("FAIL ri_regimm got=%b exp=1000", {riD, branchD, jumpD, jrD});
    end
    tick();
    instrD = NOP;
    tick();
    total++;
    if ({riM, regwriteM, memWriteM, memtoRegM, hilowriteM} !== 5'b10000) begin
      bad++;
      $display("FAIL ri_M got=%b exp=10000", {riM, regwriteM, memWriteM, memtoRegM, hilowriteM});
    end
    instrD = MFHI;
    #1;
    total++;
    if ({h0_riD, riD} !== 2'b10) begin
      bad++; $display("FAIL mfhi_hilo_en got=%b exp=10", {h0_riD, riD});
    end
    instrD = NOP;
  endtask

  task automatic test_bgezal_stall();
    instrD = {6'b000001, 5'd7, 5'b10001, 16'h0010};
    #1;
    total++;
    if ({branchD, riD} !== 2'b10) begin bad++; $display("FAIL bgezal_D got=%b exp=10", {branchD, riD}); end
    tick();
    instrD = NOP; stallE = 1'b1; flushM = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin stallE = 1'b0; flushM = 1'b0; end
      total++;
      if ({balE, regwriteE} !== 2'b11 || (k > 0 && regwriteM !== 1'b0)) begin
        bad++;
        $display("FAIL bgezal_hold cyc=%0d got bal=%b rw=%b rwM=%b exp=1 1 0", k, balE, regwriteE, regwriteM);
      end
      tick();
    end
    total++;
    if ({regwriteM, balE} !== 2'b10) begin
      bad++; $display("FAIL bgezal_M got=%b exp=10", {regwriteM, balE});
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [13:0] dw;
    rst = 1'b1; ctl_clear(); instrD = NOP;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      r = $urandom();
      case ($urandom_range(0, 9))
        0:       instrD = r;
        1, 2:    instrD = {6'b0, r[25:0]};
        3:       instrD = {6'b0, r[25:6], 4'b0110, r[1:0]};
        4:       instrD = {6'b000001, r[25:0]};
        5:       instrD = {6'b000001, r[25:21], r[20], 3'b000, r[16], r[15:0]};
        default: instrD = r;
      endcase
      stallE = ($urandom_range(0, 7) == 0);
      flushE = ($urandom_range(0, 39) == 0);
      stallM = ($urandom_range(0, 9) == 0);
      flushM = ($urandom_range(0, 19) == 0);
      stallW = ($urandom_range(0, 9) == 0);
      flushW = ($urandom_range(0, 19) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      #1;
      dw = ref_dec(instrD, 1'b1);
      total++;
      if ({riD, branchD, jumpD, jrD, h0_riD} !== {dw[13], dw[3], dw[0], dw[9], ref_dec(instrD, 1'b0) == B_RI}) begin
        bad++;
        $display("FAIL rnd_D cyc=%0d instr=%h got=%b exp=%b", c, instrD,
                 {riD, branchD, jumpD, jrD, h0_riD},
                 {dw[13], dw[3], dw[0], dw[9], ref_dec(instrD, 1'b0) == B_RI});
      end
      total++;
      if ({regwriteE, regdstE, alusrcAE, alusrcBE, memtoRegE, jalE, balE, md_stall} !==
          {me[6], me[5], me[7], me[4], me[1], me[8], me[10], exp_mdst}) begin
        bad++;
        $display("FAIL rnd_E cyc=%0d got=%b exp=%b", c,
                 {regwriteE, regdstE, alusrcAE, alusrcBE, memtoRegE, jalE, balE, md_stall},
                 {me[6], me[5], me[7], me[4], me[1], me[8], me[10], exp_mdst});
      end
      total++;
      if ({regwriteM, memWriteM, memtoRegM, hilowriteM, riM, regwriteW, memtoRegW} !==
          {mm[6], mm[2], mm[1], mm[11], mm[13], mw[6], mw[1]}) begin
        bad++;
        $display("FAIL rnd_MW cyc=%0d got=%b exp=%b", c,
                 {regwriteM, memWriteM, memtoRegM, hilowriteM, riM, regwriteW, memtoRegW},
                 {mm[6], mm[2], mm[1], mm[11], mm[13], mw[6], mw[1]});
      end
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0; ctl_clear(); instrD = NOP;
  endtask

  initial begin
    rst = 1'b1; instrD = NOP; ctl_clear();
    test_reset();
    test_div();
    test_mult();
    test_flush();
    test_ri();
    test_bgezal_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_dec_pipe.md
Name: main_dec_pipe

Overview:
- Parametrised successor to the single-issue main decoder.
- Decodes the MIPS-I instruction in D into a 14-bit control word and carries it through E/M/W pipeline registers.
- Adds per-stage stall/flush, reserved-instruction (RI) detection and an internal multiply/divide busy FSM that freezes E for multi-cycle HI/LO ops.
- Sits between the instruction fetch register and the hazard unit; the hazard unit consumes md_stall.

Parameters:
- MUL_LATENCY, 1, cycles a MULT/MULTU occupies E (>=1).
- DIV_LATENCY, 32, cycles a DIV/DIVU occupies E (>=1).
- HILO_EN, 1, when 0 every HI/LO op (MULT*, DIV*, MFHI, MFLO, MTHI, MTLO) decodes as RI.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- instrD  in  32  instruction in decode stage
- stallE/flushE, stallM/flushM, stallW/flushW  in  1 each  hazard-unit controls per stage
- branchD, jumpD, jrD, riD  out  1  decode-stage controls (combinational)
- regwriteE, regdstE, alusrcAE, alusrcBE, memtoRegE, jalE, balE  out  1  E-stage controls
- regwriteM, memWriteM, memtoRegM, hilowriteM, riM  out  1  M-stage controls
- regwriteW, memtoRegW  out  1  W-stage controls
- md_stall  out  1  high while a multi-cycle HI/LO op must hold E

Behaviour:
- Control word layout is {ri, md, hilowrite, bal, jr, jal, alusrcA, regwrite, regdst, alusrcB, branch, memWrite, memtoReg, jump}, bits 13..0.
- Decode is combinational from op[31:26], rt[20:16] and funct[5:0].
- R-type decode:
  - SLL/SRL/SRA: alusrcA, regwrite, regdst.
  - SLLV/SRLV/SRAV and ALU ops: regwrite, regdst.
  - MFHI/MFLO: regwrite, regdst.
  - MTHI/MTLO: hilowrite.
  - MULT/MULTU/DIV/DIVU: hilowrite, md.
  - JR: jr, jump.
  - JALR: jr, jump, regwrite, regdst.
  - Any other funct: ri.
- I/J-type decode:
  - Loads LB/LBU/LH/LHU/LW: regwrite, alusrcB, memtoReg.
  - Stores SB/SH/SW: alusrcB, memWrite.
  - ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI: regwrite, alusrcB.
  - BEQ/BNE/BLEZ/BGTZ: branch.
  - REGIMM with rt BLTZ/BGEZ: branch. BLTZAL/BGEZAL: branch, bal, regwrite. Other rt: ri.
  - J: jump.
  - JAL: jump, jal, regwrite.
  - Unlisted opcode: ri.
- RI word: every bit except ri is 0.
- instrD = 0 (NOP = SLL $0) decodes as a shift with rd = 0. Legal.
- E register priority, top wins:
  1. rst: 0.
  2. flushE: 0.
  3. stallE or md_stall: hold.
  4. Otherwise: load the D word.
- M register priority, top wins:
  1. rst: 0.
  2. flushM: 0.
  3. stallM: hold.
  4. md_stall: load 0 (bubble).
  5. Otherwise: load E.
- W register priority, top wins:
  1. rst: 0.
  2. flushW: 0.
  3. stallW: hold.
  4. Otherwise: load M.
- Reset: all E/M/W outputs 0, FSM IDLE, cnt 0, md_stall 0.
- MD FSM: states IDLE and BUSY. cnt width is clog2(max latency + 1). lat is latched from the E op type on entry to BUSY.
  - IDLE: if E.md and the op's latency L > 1, go to BUSY, cnt <= 1, latch lat = L.
  - BUSY: if cnt != lat-1, cnt++. If cnt == lat-1 and !stallE, go to IDLE and cnt <= 0. If cnt == lat-1 and stallE, hold BUSY.
  - flushE or rst in any state: go to IDLE, cnt <= 0.
- md_stall = (IDLE && E.md && L > 1 && !flushE) || (BUSY && cnt != lat-1).
- Result: an MD op stays in E exactly L cycles (absent external stalls), with md_stall high for L-1 of them; M sees L-1 bubbles.
- Latency 1: md_stall is never asserted for that op type.
- Back-to-back MD ops: the second enters E on the cycle after release and starts a fresh count from IDLE.

Test Plan:
- Reset, then LW (op 100011) in D → next cycle regwriteE=1, alusrcBE=1, memtoRegE=1. Two cycles later regwriteW=1, memtoRegW=1. During reset all outputs are 0.
- DIV (funct 011010), DIV_LATENCY=32 → md_stall high for 31 consecutive cycles starting the cycle DIV is in E. M holds 0 throughout. hilowriteM=1 exactly one cycle after md_stall falls.
- MULT with MUL_LATENCY=1 followed by ADDU → md_stall never rises; hilowriteM and regwriteM appear on consecutive cycles.
- DIV in E, flushE at busy cycle 5 → next cycle FSM IDLE, md_stall=0, E word 0, hilowriteM never asserted.
- Opcode 111111, and REGIMM with rt=00010 → riD=1 and all other D controls 0. riM=1 two cycles later. With HILO_EN=0, MFHI → riD=1.
- BGEZAL (op 000001, rt 10001) with stallE asserted for 2 cycles → branchD=1. balE=1, regwriteE=1 held for 3 cycles. M receives the word once stallE drops.
